// File: rtl/vga_axil_regs_if.sv
// AXI4-lite types and bus interface shared by the VGA register block and its bus master.
package vga_axil_pkg;
  typedef logic [31:0] axil_addr_t;
  typedef logic [31:0] axil_data_t;
endpackage

interface vga_axil_if;
  localparam int STRB_W = $bits(vga_axil_pkg::axil_data_t) / 8;

  vga_axil_pkg::axil_addr_t awaddr;
  logic                     awvalid;
  logic                     awready;
  vga_axil_pkg::axil_data_t wdata;
  logic [STRB_W-1:0]        wstrb;
  logic                     wvalid;
  logic                     wready;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;
  vga_axil_pkg::axil_addr_t araddr;
  logic                     arvalid;
  logic                     arready;
  vga_axil_pkg::axil_data_t rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vga_axil_regs.sv
// AXI4-lite register block for the VGA controller: REG_NUM RW words plus a read-only STATUS word.
// Define VGA_AXIL_REGS_DECERR_EN to answer unmapped accesses with DECERR instead of OKAY.
module vga_axil_regs #(
  parameter type axil_addr_t = vga_axil_pkg::axil_addr_t,
  parameter type axil_data_t = vga_axil_pkg::axil_data_t,
  parameter int REG_NUM = 4,
  parameter logic [REG_NUM-1:0][31:0] REG_RST = '0
) (
  input  logic                     clk,
  input  logic                     arst,
  vga_axil_if.slave                axil,
  output logic [REG_NUM-1:0][31:0] regs_o,
  output logic [REG_NUM-1:0]       wr_pulse_o,
  input  logic [31:0]              status_i
);
  localparam int STRB_W = $bits(axil_data_t) / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef VGA_AXIL_REGS_DECERR_EN
  localparam logic [1:0] UNMAPPED_RESP = 2'b11;
`else
  localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

  // IDLE: nothing held | HALF: one of AW/W held | RESP: bvalid high
  typedef enum logic [1:0] {IDLE, HALF, RESP} wr_state_e;

  wr_state_e                 wr_state_q;
  logic                      aw_pending_q, w_pending_q, bvalid_q, rvalid_q;
  axil_addr_t                awaddr_q;
  axil_data_t                wdata_q, rdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic [1:0]                bresp_q, rresp_q;
  logic [REG_NUM-1:0][31:0]  regs_q;
  logic [REG_NUM-1:0]        wr_pulse_q;

  logic                      aw_hs, w_hs, ar_hs, commit;
  axil_addr_t                wr_addr_d, wr_idx_d, rd_idx_d;
  axil_data_t                wr_data_d, wr_mask_d, rd_data_d;
  logic [STRB_W-1:0]         wr_strb_d;
  logic [REG_NUM-1:0]        wr_sel_d;
  logic [1:0]                wr_resp_d, rd_resp_d;

  assign axil.awready = !aw_pending_q && !bvalid_q && !arst;
  assign axil.wready  = !w_pending_q && !bvalid_q && !arst;
  assign axil.arready = !rvalid_q && !arst;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = bresp_q;
  assign axil.rvalid  = rvalid_q;
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;
  assign regs_o       = regs_q;
  assign wr_pulse_o   = wr_pulse_q;

  assign aw_hs  = axil.awvalid && axil.awready;
  assign w_hs   = axil.wvalid && axil.wready;
  assign ar_hs  = axil.arvalid && axil.arready;
  // A channel arriving on the commit edge is used directly instead of via its holding register.
  assign commit = (aw_pending_q || aw_hs) && (w_pending_q || w_hs);

  always_comb begin
    wr_addr_d = aw_pending_q ? awaddr_q : axil.awaddr;
    wr_data_d = w_pending_q ? wdata_q : axil.wdata;
    wr_strb_d = w_pending_q ? wstrb_q : axil.wstrb;
    wr_idx_d  = wr_addr_d >> 2;
    rd_idx_d  = axil.araddr >> 2;
    wr_mask_d = '0;
    for (int k = 0; k < STRB_W; k++) wr_mask_d[8*k +: 8] = {8{wr_strb_d[k]}};
    wr_sel_d  = '0;
    wr_resp_d = UNMAPPED_RESP;
    rd_data_d = '0;
    rd_resp_d = UNMAPPED_RESP;
    for (int i = 0; i < REG_NUM; i++) begin
      if (wr_idx_d == axil_addr_t'(i)) begin
        wr_sel_d[i] = 1'b1;
        wr_resp_d   = RESP_OKAY;
      end
      if (rd_idx_d == axil_addr_t'(i)) begin
        rd_data_d = regs_q[i];
        rd_resp_d = RESP_OKAY;
      end
    end
    if (wr_idx_d == axil_addr_t'(REG_NUM)) wr_resp_d = RESP_SLVERR;
    if (rd_idx_d == axil_addr_t'(REG_NUM)) begin
      rd_data_d = status_i;
      rd_resp_d = RESP_OKAY;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_state_q   <= IDLE;
      aw_pending_q <= 1'b0;
      w_pending_q  <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      regs_q       <= REG_RST;
      wr_pulse_q   <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (aw_hs) awaddr_q <= axil.awaddr;
      if (w_hs) begin
        wdata_q <= axil.wdata;
        wstrb_q <= axil.wstrb;
      end
      case (wr_state_q)
        IDLE, HALF: begin
          if (commit) begin
            wr_state_q   <= RESP;
            aw_pending_q <= 1'b0;
            w_pending_q  <= 1'b0;
            bvalid_q     <= 1'b1;
            bresp_q      <= wr_resp_d;
            for (int i = 0; i < REG_NUM; i++) begin
              if (wr_sel_d[i]) begin
                regs_q[i]     <= (regs_q[i] & ~wr_mask_d) | (wr_data_d & wr_mask_d);
                wr_pulse_q[i] <= 1'b1;
              end
            end
          end else begin
            if (aw_hs) aw_pending_q <= 1'b1;
            if (w_hs) w_pending_q <= 1'b1;
            if (aw_hs || w_hs) wr_state_q <= HALF;
          end
        end
        RESP: begin
          if (axil.bready) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= IDLE;
          end
        end
        default: wr_state_q <= IDLE;
      endcase
    end
  end

  // A read sampled on a commit edge sees regs_q before that commit lands.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_d;
      rresp_q  <= rd_resp_d;
    end else if (rvalid_q && axil.rready) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_axil_regs.sv
// Scoreboard bench for vga_axil_regs: drivers queue expected B/R responses, a negedge monitor checks them.
module tb_vga_axil_regs;
  localparam logic [3:0][31:0] TB_RST = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
`ifdef VGA_AXIL_REGS_DECERR_EN
  localparam logic [1:0] UNM = 2'b11;
`else
  localparam logic [1:0] UNM = 2'b00;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic [3:0][31:0] regs_o;
  logic [3:0]       wr_pulse_o;
  logic [31:0]      status_i = '0;
  logic [3:0][31:0] exp_regs;
  logic [1:0]       bq[$];
  r_exp_t           rq[$];
  r_exp_t           r_head;
  int               n_checks = 0;
  int               n_fail = 0;
  int               pulse_cnt[4] = '{0, 0, 0, 0};
  bit               flag_ok;

  vga_axil_if axil();

  vga_axil_regs #(.REG_NUM(4), .REG_RST(TB_RST)) dut (
    .clk        (clk),
    .arst       (arst),
    .axil       (axil),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o),
    .status_i   (status_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      for (int i = 0; i < 4; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
      if (axil.bvalid && axil.bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", axil.bresp, bq.pop_front());
      end
      if (axil.rvalid && axil.rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          r_head = rq.pop_front();
          chk("rdata", axil.rdata, r_head.data);
          chk("rresp", axil.rresp, r_head.resp);
        end
      end
    end
  end

  // All drivers start and end just after a rising edge.
  task automatic wait_b();
    int c = 0;
    @(negedge clk);
    chk("b_latency", axil.bvalid, 1);
    while (!axil.bvalid && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_go, w_go;
    int c = 0;
    bq.push_back(er);
    axil.awaddr = a;
    axil.wdata  = d;
    axil.wstrb  = s;
    axil.bready = 1'b1;
    while (!(aw_done && w_done) && c < 50) begin
      axil.awvalid = !aw_done && (c >= aw_dly);
      axil.wvalid  = !w_done && (c >= w_dly);
      @(negedge clk);
      aw_go = axil.awvalid && axil.awready;
      w_go  = axil.wvalid && axil.wready;
      @(posedge clk); #1;
      if (aw_go) aw_done = 1;
      if (w_go) w_done = 1;
      c++;
    end
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    chk("write_hs_done", {aw_done, w_done}, 2'b11);
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
    bit go = 0;
    int c = 0;
    rq.push_back('{data: d, resp: er});
    axil.araddr  = a;
    axil.arvalid = 1'b1;
    axil.rready  = 1'b1;
    while (!go && c < 20) begin
      @(negedge clk);
      go = axil.arready;
      @(posedge clk); #1;
      c++;
    end
    axil.arvalid = 1'b0;
    chk("read_hs_done", go, 1);
    @(negedge clk);
    chk("r_latency", axil.rvalid, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axil.awaddr = '0; axil.awvalid = 0; axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 0;
    axil.bready = 0; axil.araddr = '0; axil.arvalid = 0; axil.rready = 0;
    exp_regs = TB_RST;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_regs", regs_o, TB_RST);
    chk("rst_ctrl", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid, wr_pulse_o}, 0);
    chk("rst_resp_data", {axil.bresp, axil.rresp, axil.rdata}, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    #1;
    chk("rel_readies", {axil.awready, axil.wready, axil.arready}, 3'b111);
    @(posedge clk); #1;

    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0);
    exp_regs[1] = 32'hDEAD_BEEF;
    chk("full_write_regs", regs_o, exp_regs);
    chk("full_write_pulses", {pulse_cnt[3], pulse_cnt[2], pulse_cnt[1], pulse_cnt[0]}, {32'd0, 32'd0, 32'd1, 32'd0});
    do_read(32'h04, 32'hDEAD_BEEF, 2'b00);

    do_write(32'h04, 32'h1122_3344, 4'b0101, 2'b00, 0, 0);
    exp_regs[1] = 32'hDE22_BE44;
    chk("partial_strobe", regs_o, exp_regs);

    do_write(32'h0C, 32'h0BAD_F00D, 4'b1100, 2'b00, 2, 0);
    exp_regs[3] = 32'h0BAD_4444;
    chk("w_first_regs", regs_o, exp_regs);
    do_write(32'h00, 32'hFFFF_FFFF, 4'b0000, 2'b00, 0, 0);
    chk("zero_strb_regs", regs_o, exp_regs);
    chk("zero_strb_pulse", pulse_cnt[0], 1);

    bq.push_back(2'b00);
    axil.bready  = 1'b0;
    axil.awaddr  = 32'h08;
    axil.awvalid = 1'b1;
    @(negedge clk);
    chk("bp_awready", axil.awready, 1);
    @(posedge clk); #1;
    axil.awvalid = 1'b0;
    flag_ok = 1;
    repeat (2) begin
      @(negedge clk);
      if (axil.bvalid || axil.awready || !axil.wready) flag_ok = 0;
      @(posedge clk); #1;
    end
    chk("bp_aw_held", flag_ok, 1);
    axil.wdata  = 32'hCAFE_F00D;
    axil.wstrb  = 4'hF;
    axil.wvalid = 1'b1;
    @(negedge clk);
    chk("bp_wready", axil.wready, 1);
    @(posedge clk); #1;
    axil.wvalid = 1'b0;
    @(negedge clk);
    exp_regs[2] = 32'hCAFE_F00D;
    chk("bp_bvalid_c4", {axil.bvalid, wr_pulse_o}, 5'b1_0100);
    chk("bp_regs", regs_o, exp_regs);
    flag_ok = 1;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!axil.bvalid || axil.bresp !== 2'b00 || axil.awready || axil.wready) flag_ok = 0;
    end
    chk("bp_stable", flag_ok, 1);
    @(posedge clk); #1;
    axil.bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release", {axil.bvalid, axil.awready, axil.wready}, 3'b011);
    @(posedge clk); #1;

    do_read(32'h0C, 32'h0BAD_4444, 2'b00);
    do_read(32'h00, 32'h1111_1111, 2'b00);
    do_read(32'h07, 32'hDE22_BE44, 2'b00);

    status_i = 32'h0000_00A5;
    do_read(32'h10, 32'h0000_00A5, 2'b00);
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0);
    chk("status_wr_regs", regs_o, exp_regs);
    chk("status_wr_pulses", {pulse_cnt[3], pulse_cnt[2], pulse_cnt[1], pulse_cnt[0]}, {32'd1, 32'd1, 32'd2, 32'd1});

    do_read(32'h100, 32'h0, UNM);
    do_write(32'h100, 32'h1, 4'hF, UNM, 0, 0);
    chk("unmapped_regs", regs_o, exp_regs);
    chk("unmapped_pulses", {pulse_cnt[3], pulse_cnt[2], pulse_cnt[1], pulse_cnt[0]}, {32'd1, 32'd1, 32'd2, 32'd1});

    repeat (3) @(posedge clk);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
